// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default
// operand width and the bit-counter sizing rule.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit word still needs a one-bit counter ($clog2(1) would be 0).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational full subtractor: d = a - b - bi, with borrow-out bo.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock through a
// single shared full-subtractor cell, with a start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             accept;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH:0]   diff_ext;

    fs_cell u_fs_cell (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign accept   = ready & start;
    assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign diff_ext = {cell_d, diff_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // done comes straight from the state register, so it cannot glitch.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE: ready = 1'b1;
            RUN:  busy  = 1'b1;
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        bout_d = bout_q;
        if (accept) begin
            sa_d   = a;
            sb_d   = b;
            diff_d = '0;
            cnt_d  = '0;
            br_d   = 1'b0;
            bout_d = 1'b0;
        end else if (state_q == RUN) begin
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            diff_d = diff_ext[WIDTH:1];
            br_d   = cell_bo;
            // Counter parks at the last index instead of wrapping.
            if (last_bit) begin
                bout_d = cell_bo;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q   <= '0;
            sb_q   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            bout_q <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

    a_ready_busy_excl: assert property (@(posedge clk) disable iff (rst) !(ready && busy));
    a_done_single:     assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_cnt_bounded:     assert property (@(posedge clk) disable iff (rst)
                                        (state_q == RUN) |-> (cnt_q <= CNT_LAST));

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 8 and WIDTH = 1.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       ready1, busy1, done1, bout1;
    logic [0:0] diff1;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        int         cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    int cyc       = 0;
    int checks    = 0;
    int passes    = 0;
    int done8_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ready (ready1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && done8) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                checks++;
                $display("FAIL w8 done with no pending op: diff=0x%0h bout=%0b (cycle %0d)",
                         diff8, bout8, cyc);
            end else begin
                e = q8.pop_front();
                chk("w8 diff",    32'(diff8), 32'(e.diff));
                chk("w8 bout",    32'(bout8), 32'(e.bout));
                chk("w8 latency", 32'(cyc),   32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL w1 done with no pending op: diff=%0b bout=%0b (cycle %0d)",
                         diff1, bout1, cyc);
            end else begin
                e = q1.pop_front();
                chk("w1 diff",    32'(diff1), 32'(e.diff));
                chk("w1 bout",    32'(bout1), 32'(e.bout));
                chk("w1 latency", 32'(cyc),   32'(e.cyc));
            end
        end
    end

    // Reference: word-level unsigned subtraction, result mod 2^W, borrow when a < b.
    function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv, input int acc_cyc);
        exp_t e;
        e.diff = av - bv;
        e.bout = (av < bv);
        e.cyc  = acc_cyc + 8;
        return e;
    endfunction

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        int g = 0;
        while (!ready8 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!ready8) begin
            checks++;
            $display("FAIL w8 ready timeout: ready=%0b, expected 1", ready8);
        end
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        q8.push_back(model8(av, bv, cyc + 1));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic [0:0] av, input logic [0:0] bv);
        exp_t e;
        int g = 0;
        while (!ready1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!ready1) begin
            checks++;
            $display("FAIL w1 ready timeout: ready=%0b, expected 1", ready1);
        end
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        e.diff = 8'(1'(av - bv));
        e.bout = (av < bv);
        e.cyc  = cyc + 1 + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic drain8();
        int g = 0;
        while (q8.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (q8.size() != 0) begin
            checks++;
            $display("FAIL w8 drain timeout: %0d results pending, expected 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic drain1();
        int g = 0;
        while (q1.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (q1.size() != 0) begin
            checks++;
            $display("FAIL w1 drain timeout: %0d results pending, expected 0", q1.size());
            q1.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d results pending", q8.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int g;
        int base;
        logic [7:0] av, bv;

        #1 rst = 1'b1;
        #2;
        chk("reset ready", 32'(ready8), 32'd1);
        chk("reset busy",  32'(busy8),  32'd0);
        chk("reset done",  32'(done8),  32'd0);
        chk("reset diff",  32'(diff8),  32'd0);
        chk("reset bout",  32'(bout8),  32'd0);
        chk("reset w1 ready", 32'(ready1), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue8(8'h5A, 8'h3C);
        drain8();
        issue8(8'h10, 8'h20);
        drain8();
        repeat (3) @(negedge clk);
        chk("idle hold diff", 32'(diff8),  32'hF0);
        chk("idle hold bout", 32'(bout8),  32'd1);
        chk("idle ready",     32'(ready8), 32'd1);
        issue8(8'h00, 8'h01);
        drain8();
        issue8(8'hFF, 8'hFF);
        drain8();
        repeat (2) @(negedge clk);

        // start held high with changing operands for the whole RUN phase
        a8 = 8'h96;
        b8 = 8'h69;
        start8 = 1'b1;
        q8.push_back(model8(8'h96, 8'h69, cyc + 1));
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        chk("held start busy cycles", 32'(busy_cnt), 32'd8);
        chk("busy low in done",       32'(busy8),    32'd0);
        drain8();
        repeat (2) @(negedge clk);

        // back-to-back: second start issued in the DONE cycle of the first
        issue8(8'h42, 8'h13);
        g = 0;
        while (!done8 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("b2b first done seen", 32'(done8), 32'd1);
        issue8(8'h80, 8'h01);
        drain8();
        repeat (2) @(negedge clk);

        // asynchronous reset in RUN cycle 4
        issue8(8'h37, 8'h21);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort ready", 32'(ready8), 32'd1);
        chk("abort busy",  32'(busy8),  32'd0);
        chk("abort done",  32'(done8),  32'd0);
        chk("abort diff",  32'(diff8),  32'd0);
        chk("abort bout",  32'(bout8),  32'd0);
        q8.delete();
        base = done8_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no done after abort", 32'(done8_cnt), 32'(base));
        issue8(8'h03, 8'h05);
        drain8();
        repeat (2) @(negedge clk);

        issue1(1'b0, 1'b1);
        drain1();
        for (int i = 0; i < 4; i++) begin
            issue1(1'(i >> 1), 1'(i));
            if (i[0]) drain1();
        end
        drain1();

        for (int n = 0; n < 1000; n++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            case ($urandom_range(0, 15))
                0: av = 8'h00;
                1: av = 8'hFF;
                2: bv = 8'h00;
                3: bv = 8'hFF;
                4: bv = av;
                default: ;
            endcase
            issue8(av, bv);
            if ($urandom_range(0, 1) == 1) begin
                drain8();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain8();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
